// File: rtl/elevator_request_panel_pkg.sv
// Shared constants and helpers for the elevator request panel: display codes,
// door patterns, service FSM encoding and next-target selection.
package elevator_request_panel_pkg;

    localparam logic [6:0] DISP_F1 = 7'b0110000;
    localparam logic [6:0] DISP_F2 = 7'b1101101;
    localparam logic [6:0] DISP_F3 = 7'b1111001;

    localparam logic [5:0] CLOSE = 6'b111111;
    localparam logic [5:0] OPEN1 = 6'b110011;
    localparam logic [5:0] OPEN2 = 6'b100001;
    localparam logic [5:0] OPEN3 = 6'b000000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPENING = 2'd1,
        ST_SERVED  = 2'd2,
        ST_CLOSING = 2'd3
    } svc_state_e;

    typedef logic [3:1] floor_mask_t;

    function automatic floor_mask_t floor_bit(input logic [1:0] f);
        case (f)
            2'd1:    floor_bit = 3'b001;
            2'd2:    floor_bit = 3'b010;
            2'd3:    floor_bit = 3'b100;
            default: floor_bit = 3'b000;
        endcase
    endfunction

    // Current floor wins, then nearest in the travel direction, then nearest behind.
    function automatic logic [1:0] pick_target(input floor_mask_t pend,
                                               input logic [1:0] cur,
                                               input logic up);
        logic [1:0] above;
        logic [1:0] below;
        above = 2'd0;
        below = 2'd0;
        case (cur)
            2'd1: above = pend[2] ? 2'd2 : (pend[3] ? 2'd3 : 2'd0);
            2'd2: begin
                above = pend[3] ? 2'd3 : 2'd0;
                below = pend[1] ? 2'd1 : 2'd0;
            end
            default: below = pend[2] ? 2'd2 : (pend[1] ? 2'd1 : 2'd0);
        endcase
        if ((pend & floor_bit(cur)) != 3'b000)
            pick_target = cur;
        else if (up)
            pick_target = (above != 2'd0) ? above : below;
        else
            pick_target = (below != 2'd0) ? below : above;
    endfunction

endpackage

// File: rtl/elevator_request_panel_if.sv
// Pin/controller-side bundle of the request panel; slave = panel, master = controller/pins.
interface elevator_request_panel_if;

    logic [3:1] fb_n;
    logic [3:1] call_n;
    logic [6:0] fi;
    logic [5:0] door;
    logic       ud;

    logic [3:1] req_fb;
    logic [3:1] req_call;
    logic       req_any;
    logic [1:0] cur_floor;
    logic       fi_err;
    logic       served;
    logic [1:0] target;
    logic       target_vld;
    elevator_request_panel_pkg::svc_state_e svc_state;

    modport slave (
        input  fb_n, call_n, fi, door, ud,
        output req_fb, req_call, req_any, cur_floor, fi_err, served,
               target, target_vld, svc_state
    );

    modport master (
        output fb_n, call_n, fi, door, ud,
        input  req_fb, req_call, req_any, cur_floor, fi_err, served,
               target, target_vld, svc_state
    );

endinterface

// File: rtl/elevator_request_panel_button_debounce.sv
// button_debounce: 2-flop synchronizer, saturating low-sample counter and a
// single press pulse per low run of DEBOUNCE_CYCLES samples.
module elevator_request_panel_button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // press is registered, so it is high on the cycle the count reads CNT_MAX.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= !sync2 && (cnt == CNT_ARM);
            if (sync2)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/elevator_request_panel.sv
// Latches debounced button presses into pending requests, tracks floor/door state
// from the controller outputs, clears served floors and publishes the next target.
module elevator_request_panel
    import elevator_request_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    elevator_request_panel_if.slave   bus
);

    floor_mask_t press_fb;
    floor_mask_t press_call;

    for (genvar f = 1; f <= 3; f++) begin : g_btn
        elevator_request_panel_button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_fb (
            .clk  (clk),
            .reset(reset),
            .btn_n(bus.fb_n[f]),
            .press(press_fb[f])
        );
        elevator_request_panel_button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_call (
            .clk  (clk),
            .reset(reset),
            .btn_n(bus.call_n[f]),
            .press(press_call[f])
        );
    end

    logic        fi_legal;
    logic [1:0]  fi_floor;
    logic        door_open3;
    logic        door_closed;

    always_comb begin
        fi_legal = 1'b1;
        fi_floor = 2'd1;
        case (bus.fi)
            DISP_F1: fi_floor = 2'd1;
            DISP_F2: fi_floor = 2'd2;
            DISP_F3: fi_floor = 2'd3;
            default: fi_legal = 1'b0;
        endcase
    end

    // Unrecognised door codes count as closed.
    assign door_open3  = (bus.door == OPEN3);
    assign door_closed = !((bus.door == OPEN1) || (bus.door == OPEN2) || door_open3);

    svc_state_e  state_q;
    svc_state_e  state_next;
    logic        service_hit;
    logic        in_served;

    floor_mask_t req_fb_q;
    floor_mask_t req_call_q;
    logic [1:0]  cur_floor_q;
    logic        fi_err_q;
    logic        served_q;
    logic [1:0]  target_q;
    logic        target_vld_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE:    if (!door_closed) state_next = ST_OPENING;
            ST_OPENING: begin
                if (door_open3 && !fi_err_q) state_next = ST_SERVED;
                else if (door_closed)        state_next = ST_IDLE;
            end
            ST_SERVED:  if (!door_open3) state_next = ST_CLOSING;
            ST_CLOSING: if (door_closed) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        service_hit = (state_q == ST_OPENING) && door_open3 && !fi_err_q;
        in_served   = (state_q == ST_SERVED);
    end

    // The current floor stays masked for the whole SERVED stay, so late presses are absorbed.
    floor_mask_t clr_mask;
    floor_mask_t pend;

    assign clr_mask = (service_hit || in_served) ? floor_bit(cur_floor_q) : 3'b000;
    assign pend     = (req_fb_q | req_call_q) & ~(in_served ? floor_bit(cur_floor_q) : 3'b000);

    always_ff @(posedge clk) begin
        if (reset) begin
            req_fb_q     <= '0;
            req_call_q   <= '0;
            cur_floor_q  <= 2'd1;
            fi_err_q     <= 1'b0;
            served_q     <= 1'b0;
            target_q     <= 2'd1;
            target_vld_q <= 1'b0;
        end else begin
            req_fb_q   <= (req_fb_q | press_fb) & ~clr_mask;
            req_call_q <= (req_call_q | press_call) & ~clr_mask;
            fi_err_q   <= !fi_legal;
            if (fi_legal)
                cur_floor_q <= fi_floor;
            served_q     <= service_hit;
            target_vld_q <= (pend != 3'b000);
            if (pend != 3'b000)
                target_q <= pick_target(pend, cur_floor_q, bus.ud);
        end
    end

    assign bus.req_fb     = req_fb_q;
    assign bus.req_call   = req_call_q;
    assign bus.req_any    = |(req_fb_q | req_call_q);
    assign bus.cur_floor  = cur_floor_q;
    assign bus.fi_err     = fi_err_q;
    assign bus.served     = served_q;
    assign bus.target     = target_q;
    assign bus.target_vld = target_vld_q;
    assign bus.svc_state  = state_q;

endmodule

// File: tb/tb_elevator_request_panel.sv
// Bench for elevator_request_panel: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the panel.
module tb_elevator_request_panel;
    import elevator_request_panel_pkg::*;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    elevator_request_panel_if bus();

    elevator_request_panel #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    typedef struct { int due; int btn; } ev_t;

    logic [3:1] m_req_fb, m_req_call;
    int         m_cur;
    logic       m_err, m_served, m_vld;
    int         m_target;
    int         m_phase;   // 0 shut, 1 opening, 2 serviced, 3 closing
    int         run [6];
    ev_t        evq [$];
    int         cyc = 0;

    logic       hit, closed;
    logic [3:1] mask, pend, nfb, ncall;
    int         fnow;

    function automatic logic pin_low(input int b);
        if (b < 3) return bus.fb_n[b+1] == 1'b0;
        return bus.call_n[b-2] == 1'b0;
    endfunction

    function automatic int fi_to_floor(input logic [6:0] c);
        if (c == 7'b0110000) return 1;
        if (c == 7'b1101101) return 2;
        if (c == 7'b1111001) return 3;
        return 0;
    endfunction

    function automatic int pick(input logic [3:1] p, input int cur, input logic up);
        int best;
        int f;
        logic dir_up;
        best = 0;
        if (p[cur]) return cur;
        for (int pass = 0; pass < 2; pass++) begin
            dir_up = (pass == 0) ? up : !up;
            for (int d = 1; d <= 2; d++) begin
                f = dir_up ? cur + d : cur - d;
                if (best == 0 && f >= 1 && f <= 3 && p[f]) best = f;
            end
        end
        return best;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_req_fb = '0; m_req_call = '0; m_cur = 1; m_err = 0; m_served = 0;
            m_target = 1; m_vld = 0; m_phase = 0;
            for (int b = 0; b < 6; b++) run[b] = 0;
            evq.delete();
        end else begin
            closed = !(bus.door == 6'b110011 || bus.door == 6'b100001 || bus.door == 6'b000000);
            hit  = (m_phase == 1) && (bus.door == 6'b000000) && !m_err;
            mask = '0;
            if (hit || m_phase == 2) mask[m_cur] = 1'b1;
            pend = m_req_fb | m_req_call;
            if (m_phase == 2) pend[m_cur] = 1'b0;
            nfb = m_req_fb; ncall = m_req_call;
            for (int i = evq.size() - 1; i >= 0; i--) begin
                if (evq[i].due == cyc) begin
                    if (evq[i].btn < 3) nfb[evq[i].btn + 1] = 1'b1;
                    else                ncall[evq[i].btn - 2] = 1'b1;
                    evq.delete(i);
                end
            end
            m_req_fb   = nfb & ~mask;
            m_req_call = ncall & ~mask;
            if (pend != 3'b000) begin
                m_target = pick(pend, m_cur, bus.ud);
                m_vld = 1;
            end else m_vld = 0;
            m_served = hit;
            case (m_phase)
                0: if (!closed) m_phase = 1;
                1: if (hit) m_phase = 2; else if (closed) m_phase = 0;
                2: if (bus.door != 6'b000000) m_phase = 3;
                default: if (closed) m_phase = 0;
            endcase
            fnow = fi_to_floor(bus.fi);
            if (fnow != 0) begin m_cur = fnow; m_err = 0; end
            else m_err = 1;
            // A run of DEB low pin samples lands in the request 3 edges later.
            for (int b = 0; b < 6; b++) begin
                if (pin_low(b)) run[b]++;
                else run[b] = 0;
                if (run[b] == DEB) evq.push_back('{due: cyc + 3, btn: b});
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_fb(input int f, input int hold);
        bus.fb_n[f] = 1'b0;
        cycles(hold);
        bus.fb_n[f] = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        cycles(2);
        checks++; if (bus.req_fb !== 3'b000) begin errors++; $display("FAIL reset_req_fb got %b exp 000", bus.req_fb); end
        checks++; if (bus.req_call !== 3'b000) begin errors++; $display("FAIL reset_req_call got %b exp 000", bus.req_call); end
        checks++; if (bus.req_any !== 1'b0) begin errors++; $display("FAIL reset_req_any got %b exp 0", bus.req_any); end
        checks++; if (bus.cur_floor !== 2'd1) begin errors++; $display("FAIL reset_cur_floor got %0d exp 1", bus.cur_floor); end
        checks++; if (bus.fi_err !== 1'b0 || bus.served !== 1'b0) begin errors++; $display("FAIL reset_err_served got %b%b exp 00", bus.fi_err, bus.served); end
        checks++; if (bus.target !== 2'd1 || bus.target_vld !== 1'b0) begin errors++; $display("FAIL reset_target got %0d/%b exp 1/0", bus.target, bus.target_vld); end
        reset = 1'b0;
        cycles(1);
    endtask

    task automatic test_short_press();
        press_fb(2, 2);
        cycles(8);
        checks++; if (bus.req_fb !== 3'b000) begin errors++; $display("FAIL short_press got %b exp 000", bus.req_fb); end
    endtask

    task automatic test_debounce_latency();
        bus.call_n[3] = 1'b0;
        cycles(6);
        checks++; if (bus.req_call !== 3'b000) begin errors++; $display("FAIL latency_early got %b exp 000", bus.req_call); end
        cycles(1);
        checks++; if (bus.req_call !== 3'b100) begin errors++; $display("FAIL latency_edge7 got %b exp 100", bus.req_call); end
        cycles(3);
        bus.call_n[3] = 1'b1;
        checks++; if (bus.req_call !== 3'b100 || bus.req_any !== 1'b1) begin errors++; $display("FAIL latency_hold got %b/%b exp 100/1", bus.req_call, bus.req_any); end
        cycles(6);
        checks++; if (bus.req_fb !== 3'b000 || bus.req_call !== 3'b100) begin errors++; $display("FAIL latency_single got %b/%b exp 000/100", bus.req_fb, bus.req_call); end
    endtask

    task automatic test_target_and_service();
        bus.fi = DISP_F1; bus.ud = 1'b1;
        bus.fb_n[2] = 1'b0; bus.fb_n[3] = 1'b0;
        cycles(8);
        bus.fb_n[2] = 1'b1; bus.fb_n[3] = 1'b1;
        cycles(3);
        checks++; if (bus.req_fb !== 3'b110) begin errors++; $display("FAIL target_req got %b exp 110", bus.req_fb); end
        checks++; if (bus.target !== 2'd2 || bus.target_vld !== 1'b1) begin errors++; $display("FAIL target_up got %0d/%b exp 2/1", bus.target, bus.target_vld); end
        bus.fi = DISP_F2;
        cycles(2);
        checks++; if (bus.cur_floor !== 2'd2) begin errors++; $display("FAIL decode_f2 got %0d exp 2", bus.cur_floor); end
        bus.door = OPEN1; cycles(1);
        bus.door = OPEN2; cycles(1);
        checks++; if (bus.served !== 1'b0) begin errors++; $display("FAIL served_early got %b exp 0", bus.served); end
        bus.door = OPEN3; cycles(1);
        checks++; if (bus.served !== 1'b1 || bus.req_fb !== 3'b100) begin errors++; $display("FAIL service got %b/%b exp 1/100", bus.served, bus.req_fb); end
        cycles(1);
        checks++; if (bus.served !== 1'b0) begin errors++; $display("FAIL served_pulse got %b exp 0", bus.served); end
        checks++; if (bus.target !== 2'd3 || bus.target_vld !== 1'b1) begin errors++; $display("FAIL target_after got %0d/%b exp 3/1", bus.target, bus.target_vld); end
    endtask

    task automatic test_absorb_in_served();
        bus.call_n[2] = 1'b0;
        cycles(10);
        bus.call_n[2] = 1'b1;
        cycles(4);
        checks++; if (bus.req_call !== 3'b100) begin errors++; $display("FAIL absorb got %b exp 100", bus.req_call); end
        bus.door = OPEN2; cycles(1);
        bus.door = CLOSE; cycles(2);
    endtask

    task automatic test_fi_err();
        logic saw_served;
        saw_served = 1'b0;
        press_fb(2, 8);
        cycles(4);
        checks++; if (bus.req_fb !== 3'b110) begin errors++; $display("FAIL fierr_setup got %b exp 110", bus.req_fb); end
        bus.fi = 7'b0000000;
        cycles(1);
        checks++; if (bus.fi_err !== 1'b1 || bus.cur_floor !== 2'd2) begin errors++; $display("FAIL fierr_flag got %b/%0d exp 1/2", bus.fi_err, bus.cur_floor); end
        bus.door = OPEN1; cycles(1);
        bus.door = OPEN3;
        for (int i = 0; i < 4; i++) begin
            cycles(1);
            if (bus.served !== 1'b0) saw_served = 1'b1;
        end
        checks++; if (saw_served !== 1'b0 || bus.req_fb !== 3'b110) begin errors++; $display("FAIL fierr_noserve got %b/%b exp 0/110", saw_served, bus.req_fb); end
        bus.door = CLOSE; cycles(2);
        bus.fi = DISP_F2; cycles(2);
        checks++; if (bus.fi_err !== 1'b0) begin errors++; $display("FAIL fierr_clear got %b exp 0", bus.fi_err); end
    endtask

    task automatic test_reset_mid();
        bus.fb_n[1] = 1'b0;
        cycles(4);
        reset = 1'b1;
        cycles(1);
        checks++; if (bus.req_fb !== 3'b000 || bus.req_call !== 3'b000 || bus.req_any !== 1'b0) begin errors++; $display("FAIL midreset_req got %b/%b/%b exp 000/000/0", bus.req_fb, bus.req_call, bus.req_any); end
        checks++; if (bus.cur_floor !== 2'd1 || bus.fi_err !== 1'b0 || bus.served !== 1'b0) begin errors++; $display("FAIL midreset_state got %0d/%b/%b exp 1/0/0", bus.cur_floor, bus.fi_err, bus.served); end
        checks++; if (bus.target !== 2'd1 || bus.target_vld !== 1'b0) begin errors++; $display("FAIL midreset_target got %0d/%b exp 1/0", bus.target, bus.target_vld); end
        reset = 1'b0;
        bus.fb_n[1] = 1'b1;
        cycles(8);
        checks++; if (bus.req_fb !== 3'b000) begin errors++; $display("FAIL midreset_discard got %b exp 000", bus.req_fb); end
    endtask

    task automatic test_random();
        logic [6:0] fi_tab [4];
        logic [5:0] door_tab [5];
        fi_tab[0] = DISP_F1; fi_tab[1] = DISP_F2; fi_tab[2] = DISP_F3; fi_tab[3] = 7'b0;
        door_tab[0] = CLOSE; door_tab[1] = OPEN1; door_tab[2] = OPEN2; door_tab[3] = OPEN3; door_tab[4] = 6'b0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            checks++; if (bus.req_fb !== m_req_fb || bus.req_call !== m_req_call || bus.req_any !== |(m_req_fb | m_req_call)) begin
                errors++; $display("FAIL rnd_req cyc %0d got %b/%b/%b exp %b/%b", cyc, bus.req_fb, bus.req_call, bus.req_any, m_req_fb, m_req_call); end
            checks++; if (bus.cur_floor !== 2'(m_cur) || bus.fi_err !== m_err) begin
                errors++; $display("FAIL rnd_floor cyc %0d got %0d/%b exp %0d/%b", cyc, bus.cur_floor, bus.fi_err, m_cur, m_err); end
            checks++; if (bus.served !== m_served) begin
                errors++; $display("FAIL rnd_served cyc %0d got %b exp %b", cyc, bus.served, m_served); end
            checks++; if (bus.target !== 2'(m_target) || bus.target_vld !== m_vld) begin
                errors++; $display("FAIL rnd_target cyc %0d got %0d/%b exp %0d/%b", cyc, bus.target, bus.target_vld, m_target, m_vld); end
            for (int f = 1; f <= 3; f++) begin
                if ($urandom_range(0, 9) == 0) bus.fb_n[f] = ~bus.fb_n[f];
                if ($urandom_range(0, 9) == 0) bus.call_n[f] = ~bus.call_n[f];
            end
            if ($urandom_range(0, 7) == 0) begin
                bus.fi = fi_tab[$urandom_range(0, 3)];
                if (bus.fi == 7'b0) bus.fi = 7'($urandom_range(0, 127));
            end
            if ($urandom_range(0, 2) == 0) begin
                bus.door = door_tab[$urandom_range(0, 4)];
                if (bus.door == 6'b0 && $urandom_range(0, 3) == 0) bus.door = 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 15) == 0) bus.ud = ~bus.ud;
            reset = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.fb_n = 3'b111; bus.call_n = 3'b111;
        bus.fi = DISP_F1; bus.door = CLOSE; bus.ud = 1'b1;
        test_reset();
        test_short_press();
        test_debounce_latency();
        test_target_and_service();
        test_absorb_in_served();
        test_fi_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
